// File: rtl/mem_pkg.sv
// Shared definitions for the 1R1W byte-enable RAM.
//   - Parameter defaults used by ram_1r1w_be and ram_rd_pipe.
//   - State encoding of the clear sweep FSM (IDLE / CLEAR).
package mem_pkg;

   localparam int WORD_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 8;
   localparam int BYTE_WIDTH_DEF = 8;
   localparam int RD_LATENCY_DEF = 1;
   localparam int INIT_EN_DEF    = 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read result pipeline for ram_1r1w_be.
//   clk, rst_n   : clock, asynchronous active-low reset
//   rd_acc_i     : a read is accepted at this edge
//   hit_i        : an accepted write targets the same address this cycle
//   wmask_i      : bit mask of the lanes that write is updating
//   wdata_i      : write data of that cycle
//   mem_rd_i     : registered array output (pre-write contents)
//   data_o       : held read result (write-first merged)
//   rd_valid_o   : one-cycle pulse when data_o carries a new result
// The array read register holds the contents from *before* a same-cycle
// write, so the written lanes are patched in here one cycle later.
module ram_rd_pipe
   import mem_pkg::*;
#(
   parameter int Word_Width = WORD_WIDTH_DEF,
   parameter int Rd_Latency = RD_LATENCY_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_acc_i,
   input  logic                  hit_i,
   input  logic [Word_Width-1:0] wmask_i,
   input  logic [Word_Width-1:0] wdata_i,
   input  logic [Word_Width-1:0] mem_rd_i,
   output logic [Word_Width-1:0] data_o,
   output logic                  rd_valid_o
);

   logic                  v1_q;
   logic [Word_Width-1:0] mask_q, mask_d;
   logic [Word_Width-1:0] wdata_q, wdata_d;
   logic [Word_Width-1:0] merged;

   // Collision info is captured alongside the read; a mask of zero means
   // "no same-address write", so the merge degenerates to the array word.
   always_comb begin
      mask_d  = mask_q;
      wdata_d = wdata_q;
      if (rd_acc_i) begin
         mask_d  = hit_i ? wmask_i : '0;
         wdata_d = wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         mask_q  <= '0;
         wdata_q <= '0;
      end else begin
         v1_q    <= rd_acc_i;
         mask_q  <= mask_d;
         wdata_q <= wdata_d;
      end
   end

   assign merged = (mem_rd_i & ~mask_q) | (wdata_q & mask_q);

   if (Rd_Latency == 1) begin : g_lat1
      logic [Word_Width-1:0] hold_q, hold_d;

      // Result is presented straight off the array register in its first
      // valid cycle, then held in hold_q until the next result arrives.
      always_comb hold_d = v1_q ? merged : hold_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) hold_q <= '0;
         else        hold_q <= hold_d;
      end

      assign data_o     = hold_d;
      assign rd_valid_o = v1_q;
   end else begin : g_lat2
      logic [Word_Width-1:0] out_q, out_d;
      logic                  v2_q;

      always_comb out_d = v1_q ? merged : out_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_q <= '0;
            v2_q  <= 1'b0;
         end else begin
            out_q <= out_d;
            v2_q  <= v1_q;
         end
      end

      assign data_o     = out_q;
      assign rd_valid_o = v2_q;
   end

endmodule

// File: rtl/ram_1r1w_be.sv
// Single-clock RAM, one read port and one byte-lane-masked write port,
// with a self-clearing sweep FSM.
//   clk, rst_n        : clock, asynchronous active-low reset
//   clr_i / busy_o    : start a zeroing sweep / sweep in progress
//   wcen_i, wen_i     : write enable and per-lane enables (active-low)
//   waddr_i, data_i   : write address and data
//   rcen_i, raddr_i   : read enable (active-low) and address
//   oen_i             : output enable (active-low), forces data_o to zero
//   data_o, rd_valid_o: read result and its one-cycle valid pulse
// The array itself is never reset; only control state is.
module ram_1r1w_be
   import mem_pkg::*;
#(
   parameter int Word_Width = WORD_WIDTH_DEF,
   parameter int Addr_Width = ADDR_WIDTH_DEF,
   parameter int Byte_Width = BYTE_WIDTH_DEF,
   parameter int Rd_Latency = RD_LATENCY_DEF,
   parameter int Init_En    = INIT_EN_DEF
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             clr_i,
   output logic                             busy_o,
   input  logic                             wcen_i,
   input  logic [Word_Width/Byte_Width-1:0] wen_i,
   input  logic [Addr_Width-1:0]            waddr_i,
   input  logic [Word_Width-1:0]            data_i,
   input  logic                             rcen_i,
   input  logic                             oen_i,
   input  logic [Addr_Width-1:0]            raddr_i,
   output logic [Word_Width-1:0]            data_o,
   output logic                             rd_valid_o
);

   localparam int NB    = Word_Width / Byte_Width;
   localparam int DEPTH = 1 << Addr_Width;

   clr_state_e            state_q, state_d;
   logic [Addr_Width-1:0] clr_cnt_q, clr_cnt_d;
   logic                  init_pend_q, init_pend_d;

   logic                  busy, wr_acc, rd_acc, rd_hit;
   logic [NB-1:0]         lane_we;
   logic [Word_Width-1:0] wr_mask;
   logic [Word_Width-1:0] wr_data;
   logic [Addr_Width-1:0] wr_addr;
   logic [Word_Width-1:0] mem [DEPTH];
   logic [Word_Width-1:0] mem_rd_q;
   logic [Word_Width-1:0] pipe_data;

   assign busy   = (state_q == ST_CLEAR);
   assign wr_acc = ~wcen_i & ~busy;
   assign rd_acc = ~rcen_i & ~busy;
   assign rd_hit = wr_acc & (waddr_i == raddr_i);

   // Clear sweep. init_pend_q is set by reset so the first edge after
   // release launches the power-up clear; reset mid-sweep restarts at 0.
   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      init_pend_d = init_pend_q;
      unique case (state_q)
         ST_IDLE: begin
            if (clr_i || init_pend_q) begin
               state_d     = ST_CLEAR;
               clr_cnt_d   = '0;
               init_pend_d = 1'b0;
            end
         end
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (&clr_cnt_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         clr_cnt_q   <= '0;
         init_pend_q <= (Init_En != 0);
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         init_pend_q <= init_pend_d;
      end
   end

   // The sweep borrows the write port: all lanes, zero data, counter address.
   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign lane_we[gi] = busy | (wr_acc & ~wen_i[gi]);
      assign wr_mask[gi*Byte_Width +: Byte_Width] = {Byte_Width{wr_acc & ~wen_i[gi]}};
   end

   assign wr_addr = busy ? clr_cnt_q : waddr_i;
   assign wr_data = busy ? '0 : data_i;

   always_ff @(posedge clk) begin
      for (int k = 0; k < NB; k++) begin
         if (lane_we[k]) mem[wr_addr][k*Byte_Width +: Byte_Width] <= wr_data[k*Byte_Width +: Byte_Width];
      end
      if (rd_acc) mem_rd_q <= mem[raddr_i];
   end

   ram_rd_pipe #(
      .Word_Width (Word_Width),
      .Rd_Latency (Rd_Latency)
   ) u_rd_pipe (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_acc_i   (rd_acc),
      .hit_i      (rd_hit),
      .wmask_i    (wr_mask),
      .wdata_i    (data_i),
      .mem_rd_i   (mem_rd_q),
      .data_o     (pipe_data),
      .rd_valid_o (rd_valid_o)
   );

   assign data_o = oen_i ? '0 : pipe_data;
   assign busy_o = busy;

endmodule

// File: tb/tb_ram_1r1w_be.sv
module tb_ram_1r1w_be;

   localparam int RD_LAT = 2;
   localparam int DEPTH  = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr_i;
   logic        busy_o;
   logic        wcen_i;
   logic [3:0]  wen_i;
   logic [3:0]  waddr_i;
   logic [31:0] data_i;
   logic        rcen_i;
   logic        oen_i;
   logic [3:0]  raddr_i;
   logic [31:0] data_o;
   logic        rd_valid_o;

   ram_1r1w_be #(
      .Word_Width (32),
      .Addr_Width (4),
      .Byte_Width (8),
      .Rd_Latency (RD_LAT),
      .Init_En    (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (clr_i),
      .busy_o     (busy_o),
      .wcen_i     (wcen_i),
      .wen_i      (wen_i),
      .waddr_i    (waddr_i),
      .data_i     (data_i),
      .rcen_i     (rcen_i),
      .oen_i      (oen_i),
      .raddr_i    (raddr_i),
      .data_o     (data_o),
      .rd_valid_o (rd_valid_o)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      int          due;
      logic [31:0] d;
   } rd_t;

   logic [31:0] m_mem [DEPTH];
   rd_t         pend[$];
   int          edge_n = 0;
   bit          m_busy = 1'b0;
   int          m_idx = 0;
   bit          m_init_pend = 1'b1;
   logic [31:0] exp_held = 32'h0;
   bit          exp_valid = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic model_reset();
      pend.delete();
      exp_held    = 32'h0;
      exp_valid   = 1'b0;
      m_busy      = 1'b0;
      m_idx       = 0;
      m_init_pend = 1'b1;
   endtask

   // One clock edge of the specified behaviour, using the inputs as they
   // stood just before the edge.
   task automatic model_edge();
      logic [31:0] rv;
      edge_n++;
      exp_valid = 1'b0;
      if (!rcen_i && !m_busy) begin
         rv = m_mem[raddr_i];
         if (!wcen_i && waddr_i == raddr_i)
            for (int k = 0; k < 4; k++)
               if (!wen_i[k]) rv[k*8 +: 8] = data_i[k*8 +: 8];
         pend.push_back('{due: edge_n + RD_LAT - 1, d: rv});
         $display("rd  addr=%0d expect=%h", raddr_i, rv);
      end
      if (!wcen_i && !m_busy) begin
         for (int k = 0; k < 4; k++)
            if (!wen_i[k]) m_mem[waddr_i][k*8 +: 8] = data_i[k*8 +: 8];
         $display("wr  addr=%0d data=%h wen=%b", waddr_i, data_i, wen_i);
      end
      if (m_busy) begin
         m_mem[m_idx] = 32'h0;
         if (m_idx == DEPTH - 1) m_busy = 1'b0;
         m_idx++;
      end else if (clr_i || m_init_pend) begin
         m_busy      = 1'b1;
         m_idx       = 0;
         m_init_pend = 1'b0;
      end
      if (pend.size() > 0 && pend[0].due == edge_n) begin
         exp_held  = pend[0].d;
         exp_valid = 1'b1;
         void'(pend.pop_front());
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst_n) model_edge();
      else exp_valid = 1'b0;
      #1;
      chk("busy", 32'(busy_o), 32'(m_busy));
      chk("valid", 32'(rd_valid_o), 32'(exp_valid));
      chk("data", data_o, oen_i ? 32'h0 : exp_held);
   endtask

   task automatic idle_in();
      wcen_i = 1'b1;
      rcen_i = 1'b1;
      clr_i  = 1'b0;
      oen_i  = 1'b0;
      wen_i  = 4'hF;
   endtask

   task automatic rand_in();
      wcen_i  = 1'($urandom_range(0, 1));
      wen_i   = 4'($urandom);
      waddr_i = 4'($urandom);
      data_i  = $urandom;
      rcen_i  = 1'($urandom_range(0, 1));
      raddr_i = ($urandom_range(0, 2) == 0) ? waddr_i : 4'($urandom);
      oen_i   = ($urandom_range(0, 9) == 0);
      clr_i   = ($urandom_range(0, 99) == 0);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we);
      wcen_i = 1'b0; waddr_i = a; data_i = d; wen_i = we;
      cyc();
      idle_in();
   endtask

   task automatic read_chk(input logic [3:0] a, input logic [31:0] e, input string tag);
      rcen_i = 1'b0; raddr_i = a;
      cyc();
      rcen_i = 1'b1;
      chk({tag, "_early"}, 32'(rd_valid_o), 32'd0);
      cyc();
      chk({tag, "_vld"}, 32'(rd_valid_o), 32'd1);
      chk(tag, data_o, e);
   endtask

   // Runs until busy_o drops (bounded); optionally randomises inputs meanwhile.
   task automatic wait_idle(input bit rnd, output int nbusy, output int nvalid, output logic [31:0] vdata);
      bit done = 1'b0;
      nbusy = 0; nvalid = 0; vdata = 32'h0;
      for (int i = 0; i < 40; i++) begin
         if (rnd) rand_in();
         cyc();
         if (rd_valid_o) begin nvalid++; vdata = data_o; end
         if (busy_o) nbusy++;
         else begin done = 1'b1; break; end
      end
      chk("busy_timeout", 32'(done), 32'd1);
      idle_in();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, nv;
      logic [31:0] vd;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      rst_n = 1'b0; waddr_i = '0; raddr_i = '0; data_i = '0;
      idle_in();
      model_reset();
      repeat (3) cyc();
      chk("rst_data", data_o, 32'h0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      rst_n = 1'b1;

      // Power-up clear, then every address reads zero.
      wait_idle(1'b0, nb, nv, vd);
      chk("init_busy_len", nb, 16);
      for (int a = 0; a < DEPTH; a++) read_chk(4'(a), 32'h0, "init_zero");

      // Lane masking.
      wr(4'd3, 32'hAABBCCDD, 4'b0000);
      wr(4'd3, 32'h11223344, 4'b1010);
      read_chk(4'd3, 32'hAA22CC44, "lane_mask");

      // Same-cycle read/write collision, write-first per lane.
      wr(4'd5, 32'h01020304, 4'b0000);
      wcen_i = 1'b0; wen_i = 4'b0011; waddr_i = 4'd5; data_i = 32'h55667788;
      rcen_i = 1'b0; raddr_i = 4'd5;
      cyc();
      idle_in();
      cyc();
      chk("collide_vld", 32'(rd_valid_o), 32'd1);
      chk("collide", data_o, 32'h55660304);

      // Clear with a read in flight and traffic during the sweep.
      wr(4'd7, 32'hDEADBEEF, 4'b0000);
      clr_i = 1'b1; rcen_i = 1'b0; raddr_i = 4'd7;
      cyc();
      idle_in();
      wait_idle(1'b1, nb, nv, vd);
      chk("clr_busy_len", nb + 1, 16);
      chk("clr_vld_cnt", nv, 1);
      chk("clr_preread", vd, 32'hDEADBEEF);
      read_chk(4'd7, 32'h0, "clr_zero");

      // Reset in the middle of a sweep.
      wr(4'd3, 32'h12345678, 4'b0000);
      read_chk(4'd3, 32'h12345678, "pre_rst");
      clr_i = 1'b1;
      cyc();
      idle_in();
      repeat (5) cyc();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_data", data_o, 32'h0);
      chk("arst_vld", 32'(rd_valid_o), 32'd0);
      chk("arst_busy", 32'(busy_o), 32'd0);
      repeat (2) cyc();
      rst_n = 1'b1;
      wait_idle(1'b0, nb, nv, vd);
      chk("rst_busy_len", nb, 16);

      // Output enable masks data but not the valid pulse or held result.
      wr(4'd2, 32'hCAFEF00D, 4'b0000);
      oen_i = 1'b1; rcen_i = 1'b0; raddr_i = 4'd2;
      cyc();
      rcen_i = 1'b1;
      cyc();
      chk("oen_vld", 32'(rd_valid_o), 32'd1);
      chk("oen_zero", data_o, 32'h0);
      oen_i = 1'b0;
      #1;
      chk("oen_held", data_o, 32'hCAFEF00D);

      // Randomised traffic against the model.
      for (int i = 0; i < 300; i++) begin
         rand_in();
         cyc();
      end
      idle_in();
      repeat (20) cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ram_1r1w_be.md
RAM_1R1W_BE -- requirements
Module: ram_1r1w_be

Interface
REQ-001 Word_Width, 32, data word width in bits; SHALL be a multiple of Byte_Width.
REQ-002 Addr_Width, 8, address width; depth SHALL be 2^Addr_Width words.
REQ-003 Byte_Width, 8, width of one write-enable lane; lane count NB = Word_Width/Byte_Width.
REQ-004 Rd_Latency, 1, read latency in cycles; legal values 1 or 2.
REQ-005 Init_En, 1, 1 = automatic memory clear after reset release.
REQ-006 clk  input  1  clock; single clock domain, all logic on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 clr_i  input  1  high-active one-cycle request to zero the whole array.
REQ-009 busy_o  output  1  high while a clear sweep is in progress.
REQ-010 wcen_i  input  1  write port enable, low active.
REQ-011 wen_i  input  NB  per-lane write enable, low active; lane k covers bits [k*Byte_Width +: Byte_Width].
REQ-012 waddr_i  input  Addr_Width  write address.
REQ-013 data_i  input  Word_Width  write data.
REQ-014 rcen_i  input  1  read port enable, low active.
REQ-015 oen_i  input  1  output enable, low active.
REQ-016 raddr_i  input  Addr_Width  read address.
REQ-017 data_o  output  Word_Width  read data.
REQ-018 rd_valid_o  output  1  high for one cycle when data_o carries a new read result.

Function
REQ-019 Write accepted when wcen_i=0 and busy_o=0; only lanes with wen_i[k]=0 SHALL be updated; others SHALL retain their contents.
REQ-020 Read accepted when rcen_i=0 and busy_o=0; result SHALL appear on data_o with rd_valid_o=1 exactly Rd_Latency cycles later.
REQ-021 Same-cycle accepted read and write to the same address SHALL return write-first data: written lanes from data_i, unwritten lanes from prior contents.
REQ-022 Read and write ports SHALL be independent; both may be accepted every cycle (full throughput).
REQ-023 data_o SHALL hold its last read result until the next accepted read completes.
REQ-024 oen_i=1 SHALL force data_o to all zeros without disturbing the held result or rd_valid_o; no tristate.
REQ-025 Clear FSM states IDLE, CLEAR; IDLE->CLEAR on clr_i=1, or on the first clock after reset release when Init_En=1.
REQ-026 CLEAR SHALL write zero to one address per cycle, ascending from 0; after writing address 2^Addr_Width-1 -> IDLE; sweep lasts exactly 2^Addr_Width cycles.
REQ-027 busy_o SHALL equal (state==CLEAR); user reads and writes presented while busy_o=1 SHALL be ignored, with no rd_valid_o pulse.
REQ-028 clr_i while in CLEAR SHALL be ignored (no restart).
REQ-029 Reads accepted before a clear starts SHALL still complete with pre-clear data.

Reset
REQ-030 rst_n=0 SHALL immediately force: data_o=0, rd_valid_o=0, busy_o=0, FSM=IDLE, clear counter=0, read pipeline empty.
REQ-031 Array contents SHALL not be reset; reset mid-sweep SHALL abort it and, with Init_En=1, restart from address 0 after release.

Structure
REQ-032 Shared package mem_pkg SHALL hold FSM state encodings (IDLE, CLEAR) and parameter defaults.
REQ-033 Read-latency/valid pipeline with collision-merge SHALL be sub-module ram_rd_pipe; array, write masking and clear FSM stay in ram_1r1w_be.

Verification (Word_Width=32, Addr_Width=4, Rd_Latency=2, Init_En=1)
REQ-034 Release reset -> busy_o=1 for exactly 16 cycles; then read every address -> 0x00000000, rd_valid_o 2 cycles after each request.
REQ-035 Write 0xAABBCCDD to addr 3, then write 0x11223344 with wen_i=4'b1010 -> read addr 3 returns 0xAA22CC44.
REQ-036 Same cycle: write 0x55667788 with wen_i=4'b0011 to addr 5 (holding 0x01020304), read addr 5 -> data_o=0x55660304.
REQ-037 Pulse clr_i with addr 7=0xDEADBEEF, present reads/writes during sweep -> no rd_valid_o, addr 7 reads 0 after busy_o falls.
REQ-038 Assert rst_n=0 at sweep cycle 6 -> outputs 0 immediately; after release busy_o high 16 cycles; oen_i=1 -> data_o=0 while rd_valid_o still pulses.
